z80_bus_responder: RTL and testbench
====================================

Name: z80_bus_responder

Overview:
- Target-side end of the Z80 CPU bus: decodes memory and I/O cycles issued by the CPU core wrapper and returns read data on the CPU data-in bus.
- Bridges memory cycles to a request/acknowledge external memory port (SDRAM/BRAM controller), inserting CPU wait states until the memory acknowledges.
- Owns the bank-select and video-control I/O latches.
- Generates the timed maskable interrupt from a frame pulse.

Parameters:
- ROM_TOP, 16'h5FFF, highest CPU address mapped to ROM when ROM is enabled.
- INT_LEN, 32, number of cep ticks int_n is held low per frame pulse.
- ADDR_W, 18, external memory address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cep  in  1  CPU clock enable (same strobe the CPU core uses)
- mreq  in  1  CPU memory request, active low
- iorq  in  1  CPU I/O request, active low
- wr  in  1  CPU write strobe, active low
- a  in  16  CPU address
- cpu_do  in  8  CPU write data
- di  out  8  read data to CPU
- wait_n  out  1  CPU wait request, active low
- int_n  out  1  maskable interrupt to CPU, active low
- frame  in  1  one-clock pulse at start of vertical blank
- mem_req  out  1  external memory request, level
- mem_we  out  1  external memory write
- mem_addr  out  ADDR_W  external memory address
- mem_wdata  out  8  external write data
- mem_rdata  in  8  external read data, valid when mem_ack=1
- mem_ack  in  1  one-clock completion pulse
- bank  out  8  bank register (port 0x7F)
- vctrl  out  8  video control register (port 0x80)

Behaviour:
- Reset values:
  - di=8'hFF, wait_n=1, int_n=1
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - bank=0, vctrl=0
  - FSM state IDLE, interrupt counter 0
- Cycle start is the falling edge of mreq or iorq, sampled on clock with cep=1, registered against the previous sampled value. One cycle is serviced per strobe assertion.
- FSM states:
  - IDLE:
    - memory start: latch a/wr/cpu_do; drive mem_req=1, mem_we=~wr, mem_addr; drive wait_n=0 in the same clock; go to MEM.
    - I/O start: go to IO.
  - MEM:
    - hold mem_req and wait_n=0 until mem_ack=1.
    - on ack, for a read capture mem_rdata into di; drop mem_req; set wait_n=1; go to HOLD.
  - IO:
    - write: a[7:0]=8'h7F loads bank; a[7:0]=8'h80 loads vctrl.
    - read: 0x7F returns bank, 0x80 returns vctrl, any other port returns 8'hFF.
    - no wait states; go to HOLD next clock.
  - HOLD: wait until both mreq=1 and iorq=1, then go to IDLE. di retains its value until the next read.
- Address mapping:
  - mem_addr = {bank[1:0], a} when ROM is disabled (vctrl[5]=1) or a > ROM_TOP.
  - otherwise mem_addr = {2'b11, a}: ROM region, writes are suppressed (no mem_req) and the cycle completes in one clock.
- Interrupt acknowledge (iorq=0 with mreq=1 during M1): treated as an I/O read of 8'hFF. The cycle is not distinguished, and int_n is not cleared early.
- int_n timing:
  - frame pulse loads counter = INT_LEN and sets int_n=0.
  - counter decrements on each cep; int_n returns to 1 when the counter reaches 0.
  - a frame pulse while counting reloads the counter.
- Simultaneous events:
  - mreq and iorq start in the same sample (illegal): memory wins.
  - frame coincident with counter expiry: reload wins, int_n stays 0.
  - mem_ack outside MEM is ignored.
- Reset mid-cycle forces IDLE and deasserts mem_req/wait_n immediately; the external controller tolerates an aborted request.
- Widths: counter sized to clog2(INT_LEN+1). mem_addr upper bits beyond 18 are zero when ADDR_W > 18.

Decomposition:
- Shared package z80_bus_pkg:
  - FSM state enum (IDLE, MEM, IO, HOLD)
  - port constants PORT_BANK=8'h7F and PORT_VCTRL=8'h80
  - ROM bank constant 2'b11
  - the open-bus value 8'hFF
- One natural sub-module: z80_int_timer (frame pulse -> int_n with INT_LEN counter).

Test Plan:
- Memory read at a=16'h8000, bank=0, ack after 5 clocks with mem_rdata=8'h3C -> mem_addr=18'h08000, mem_we=0, wait_n low exactly until ack clock, di=8'h3C.
- I/O write 8'h02 to port 0x7F, then read 0x7F and port 0x55 -> bank=8'h02, di=8'h02, then di=8'hFF, wait_n never low.
- Memory write 8'hAA to 16'h2000 with vctrl[5]=0 -> no mem_req, write dropped. Repeat with vctrl[5]=1 and bank=1 -> mem_req with mem_we=1, mem_addr=18'h12000, mem_wdata=8'hAA.
- frame pulse with INT_LEN=32 -> int_n low for exactly 32 cep ticks. Second frame pulse at tick 20 -> int_n low for 52 ticks total.
- Assert reset while in MEM awaiting ack -> next clock mem_req=0, wait_n=1, bank=0, di=8'hFF. A late mem_ack is ignored.
- Hold mreq low for 10 cep ticks after ack -> exactly one mem_req issued. A new request occurs only after mreq rises and falls again.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus responder: FSM states, I/O port
// numbers, ROM bank and open-bus value, plus small decode helpers.
package z80_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      IO   = 2'd2,
      HOLD = 2'd3
   } bus_state_t;

   localparam logic [7:0] PORT_BANK  = 8'h7F;
   localparam logic [7:0] PORT_VCTRL = 8'h80;
   localparam logic [1:0] ROM_BANK   = 2'b11;
   localparam logic [7:0] OPEN_BUS   = 8'hFF;

   // vctrl bit that unmaps the ROM when set
   localparam int VCTRL_ROM_OFF = 5;

   // Value returned for an I/O read of the given port
   function automatic logic [7:0] io_read_value(
      input logic [7:0] port,
      input logic [7:0] bank,
      input logic [7:0] vctrl
   );
      logic [7:0] value;
      case (port)
         PORT_BANK:  value = bank;
         PORT_VCTRL: value = vctrl;
         default:    value = OPEN_BUS;
      endcase
      return value;
   endfunction

   // 18-bit physical address for a CPU memory address
   function automatic logic [17:0] map_address(
      input logic [15:0] addr,
      input logic [1:0]  bank_sel,
      input logic        rom_hit
   );
      logic [17:0] phys;
      if (rom_hit) begin
         phys = {ROM_BANK, addr};
      end else begin
         phys = {bank_sel, addr};
      end
      return phys;
   endfunction

endpackage

// File: rtl/z80_int_timer.sv
// Frame-driven maskable interrupt: a frame pulse pulls int_n low for
// INT_LEN CPU clock-enable ticks; a new pulse restarts the count.
module z80_int_timer #(
   parameter int INT_LEN = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic cep,
   input  logic frame,
   output logic int_n
);

   localparam int CNT_W = (INT_LEN < 1) ? 1 : $clog2(INT_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INT_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] count_r;
   logic             int_n_r;

   // Load on frame (frame beats a coincident expiry), count down on cep
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= CNT_ZERO;
         int_n_r <= 1'b1;
      end else if (frame) begin
         count_r <= CNT_LOAD;
         int_n_r <= 1'b0;
      end else if (cep && (count_r != CNT_ZERO)) begin
         count_r <= count_r - CNT_ONE;
         if (count_r == CNT_ONE) begin
            int_n_r <= 1'b1;
         end
      end
   end

   assign int_n = int_n_r;

endmodule

// File: rtl/z80_bus_responder.sv
// Target side of the Z80 CPU bus: decodes memory and I/O cycles, bridges
// memory cycles to a req/ack memory port with CPU wait states, owns the
// bank and video-control latches and drives the frame interrupt.
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter logic [15:0] ROM_TOP = 16'h5FFF,
   parameter int          INT_LEN = 32,
   parameter int          ADDR_W  = 18
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cep,
   input  logic              mreq,
   input  logic              iorq,
   input  logic              wr,
   input  logic [15:0]       a,
   input  logic [7:0]        cpu_do,
   output logic [7:0]        di,
   output logic              wait_n,
   output logic              int_n,
   input  logic              frame,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        bank,
   output logic [7:0]        vctrl
);

   bus_state_t        state_r;
   logic              mreq_prev_r;
   logic              iorq_prev_r;
   logic [7:0]        di_r;
   logic              wait_n_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [7:0]        mem_wdata_r;
   logic [7:0]        bank_r;
   logic [7:0]        vctrl_r;
   logic [7:0]        io_port_r;
   logic              io_wr_r;
   logic [7:0]        io_wdata_r;

   logic              mem_start_s;
   logic              io_start_s;
   logic              rom_hit_s;
   logic [17:0]       phys_addr_s;

   // Strobe history, sampled only on CPU clock-enable ticks
   always_ff @(posedge clock) begin
      if (reset) begin
         mreq_prev_r <= 1'b1;
         iorq_prev_r <= 1'b1;
      end else if (cep) begin
         mreq_prev_r <= mreq;
         iorq_prev_r <= iorq;
      end
   end

   // Falling-edge cycle starts; memory wins over a simultaneous I/O start
   always_comb begin
      mem_start_s = cep & mreq_prev_r & ~mreq;
      io_start_s  = cep & iorq_prev_r & ~iorq & ~mem_start_s;
   end

   // ROM decode and physical address for the current CPU address
   always_comb begin
      if (!vctrl_r[VCTRL_ROM_OFF] && (a <= ROM_TOP)) begin
         rom_hit_s = 1'b1;
      end else begin
         rom_hit_s = 1'b0;
      end
      phys_addr_s = map_address(a, bank_r[1:0], rom_hit_s);
   end

   // Bus cycle FSM with all bus-facing outputs registered
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= IDLE;
         di_r        <= OPEN_BUS;
         wait_n_r    <= 1'b1;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= 8'h00;
         bank_r      <= 8'h00;
         vctrl_r     <= 8'h00;
         io_port_r   <= 8'h00;
         io_wr_r     <= 1'b1;
         io_wdata_r  <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (mem_start_s) begin
                  if (rom_hit_s && !wr) begin
                     // Write into ROM: dropped, cycle ends without a request
                     state_r <= HOLD;
                  end else begin
                     mem_req_r   <= 1'b1;
                     mem_we_r    <= ~wr;
                     mem_addr_r  <= ADDR_W'(phys_addr_s);
                     mem_wdata_r <= cpu_do;
                     wait_n_r    <= 1'b0;
                     state_r     <= MEM;
                  end
               end else if (io_start_s) begin
                  io_port_r  <= a[7:0];
                  io_wr_r    <= wr;
                  io_wdata_r <= cpu_do;
                  state_r    <= IO;
               end
            end
            MEM: begin
               if (mem_ack) begin
                  if (!mem_we_r) begin
                     di_r <= mem_rdata;
                  end
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  wait_n_r  <= 1'b1;
                  state_r   <= HOLD;
               end
            end
            IO: begin
               if (!io_wr_r) begin
                  if (io_port_r == PORT_BANK) begin
                     bank_r <= io_wdata_r;
                  end else if (io_port_r == PORT_VCTRL) begin
                     vctrl_r <= io_wdata_r;
                  end
               end else begin
                  // Interrupt acknowledge lands here too and reads open bus
                  di_r <= io_read_value(io_port_r, bank_r, vctrl_r);
               end
               state_r <= HOLD;
            end
            HOLD: begin
               if (mreq && iorq) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   z80_int_timer #(
      .INT_LEN (INT_LEN)
   ) u_int_timer (
      .clock (clock),
      .reset (reset),
      .cep   (cep),
      .frame (frame),
      .int_n (int_n)
   );

   assign di        = di_r;
   assign wait_n    = wait_n_r;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign bank      = bank_r;
   assign vctrl     = vctrl_r;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Self-checking bench for z80_bus_responder: directed cycles followed by
// randomized bus transactions checked against a transaction-level model.
module tb_z80_bus_responder;

   logic        clock = 1'b0;
   logic        reset, cep, mreq, iorq, wr, frame, mem_ack;
   logic [15:0] a;
   logic [7:0]  cpu_do, mem_rdata;
   logic [7:0]  di, bank, vctrl, mem_wdata;
   logic        wait_n, int_n, mem_req, mem_we;
   logic [17:0] mem_addr;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [7:0]  bank_m, vctrl_m, di_m;

   logic [15:0] ad;
   logic [7:0]  pt;
   int          cnt, guard;

   always #5 clock = ~clock;

   z80_bus_responder #(
      .ROM_TOP (16'h5FFF),
      .INT_LEN (32),
      .ADDR_W  (18)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cep       (cep),
      .mreq      (mreq),
      .iorq      (iorq),
      .wr        (wr),
      .a         (a),
      .cpu_do    (cpu_do),
      .di        (di),
      .wait_n    (wait_n),
      .int_n     (int_n),
      .frame     (frame),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bank      (bank),
      .vctrl     (vctrl)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock; inputs and samples happen 1ns after the edge, cep toggles
   task automatic tick();
      @(posedge clock);
      #1;
      cep = ~cep;
   endtask

   // ROM occupies the first 24 KiB unless vctrl bit 5 unmaps it
   function automatic bit is_rom(input logic [15:0] addr);
      return (vctrl_m[5] == 1'b0) && (addr < 16'h6000);
   endfunction

   function automatic logic [17:0] exp_addr(input logic [15:0] addr);
      if (is_rom(addr)) return {2'b11, addr};
      return {bank_m[1:0], addr};
   endfunction

   function automatic logic [7:0] exp_io_read(input logic [7:0] port);
      if (port == 8'h7F) return bank_m;
      if (port == 8'h80) return vctrl_m;
      return 8'hFF;
   endfunction

   task automatic mem_cycle(input logic [15:0] addr, input bit is_wr, input logic [7:0] wd,
                            input int ack_dly, input logic [7:0] rd, input int hold_ticks);
      bit wait_ok = 1'b1;
      int t = 0;
      int extra = 0;
      a = addr; wr = ~is_wr; cpu_do = wd; mreq = 1'b0;
      if (is_wr && is_rom(addr)) begin
         for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_req !== 1'b0 || wait_n !== 1'b1) wait_ok = 1'b0;
         end
         check("rom_write_dropped", wait_ok, 1);
      end else begin
         while (mem_req !== 1'b1 && t < 10) begin
            tick();
            t++;
         end
         check("mem_req_raised", mem_req, 1);
         if (mem_req === 1'b1) begin
            check("mem_addr", mem_addr, exp_addr(addr));
            check("mem_we", mem_we, is_wr);
            if (is_wr) check("mem_wdata", mem_wdata, wd);
            for (int i = 0; i < ack_dly; i++) begin
               if (wait_n !== 1'b0 || mem_req !== 1'b1) wait_ok = 1'b0;
               tick();
            end
            if (wait_n !== 1'b0 || mem_req !== 1'b1) wait_ok = 1'b0;
            mem_ack = 1'b1; mem_rdata = rd;
            tick();
            mem_ack = 1'b0; mem_rdata = 8'($urandom);
            check("wait_n_low_until_ack", wait_ok, 1);
            check("wait_n_after_ack", wait_n, 1);
            check("mem_req_after_ack", mem_req, 0);
            if (!is_wr) di_m = rd;
            check("di_after_mem", di, di_m);
         end
      end
      // A stray ack while the strobe is still low must be ignored
      mem_ack = 1'b1; mem_rdata = ~di_m;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < hold_ticks; i++) begin
         tick();
         if (mem_req !== 1'b0) extra++;
      end
      check("stray_ack_ignored", di, di_m);
      check("single_request", extra, 0);
      mreq = 1'b1; wr = 1'b1;
      repeat (3) tick();
   endtask

   task automatic io_cycle(input logic [7:0] port, input bit is_wr, input logic [7:0] wd);
      bit quiet = 1'b1;
      a = {8'($urandom), port}; wr = ~is_wr; cpu_do = wd; iorq = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wait_n !== 1'b1 || mem_req !== 1'b0) quiet = 1'b0;
      end
      if (is_wr) begin
         if (port == 8'h7F) bank_m = wd;
         else if (port == 8'h80) vctrl_m = wd;
      end else begin
         di_m = exp_io_read(port);
      end
      check("io_no_wait", quiet, 1);
      check("io_bank", bank, bank_m);
      check("io_vctrl", vctrl, vctrl_m);
      check("io_di", di, di_m);
      iorq = 1'b1; wr = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1; cep = 1'b0; mreq = 1'b1; iorq = 1'b1; wr = 1'b1; frame = 1'b0;
      mem_ack = 1'b0; a = 16'h0000; cpu_do = 8'h00; mem_rdata = 8'h00;
      bank_m = 8'h00; vctrl_m = 8'h00; di_m = 8'hFF;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_di", di, 8'hFF);
      check("rst_wait_n", wait_n, 1);
      check("rst_int_n", int_n, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 18'h0);
      check("rst_bank", bank, 8'h00);
      check("rst_vctrl", vctrl, 8'h00);

      // Memory read above ROM, ack after 5 clocks
      mem_cycle(16'h8000, 1'b0, 8'h00, 5, 8'h3C, 4);
      // Bank register write/read and open-bus port
      io_cycle(8'h7F, 1'b1, 8'h02);
      io_cycle(8'h7F, 1'b0, 8'h00);
      io_cycle(8'h55, 1'b0, 8'h00);
      // Write into ROM dropped, then ROM unmapped with bank 1
      mem_cycle(16'h2000, 1'b1, 8'hAA, 2, 8'h00, 2);
      io_cycle(8'h80, 1'b1, 8'h20);
      io_cycle(8'h7F, 1'b1, 8'h01);
      mem_cycle(16'h2000, 1'b1, 8'hAA, 3, 8'h00, 2);
      check("ram_write_addr", mem_addr, 18'h12000);
      // ROM read with ROM mapped back in
      io_cycle(8'h80, 1'b1, 8'h00);
      mem_cycle(16'h5FFF, 1'b0, 8'h00, 1, 8'h96, 2);
      // Strobe held low for 10 cep ticks after ack
      mem_cycle(16'hA123, 1'b0, 8'h00, 0, 8'h5A, 20);
      // Interrupt acknowledge style read
      io_cycle(8'hFF, 1'b0, 8'h00);

      // Frame interrupt: plain length
      frame = 1'b1; tick(); frame = 1'b0;
      check("int_asserted", int_n, 0);
      cnt = 0; guard = 0;
      while (int_n === 1'b0 && guard < 300) begin
         if (cep) cnt++;
         tick(); guard++;
      end
      check("int_len_32", cnt, 32);

      // Retrigger after 20 ticks
      frame = 1'b1; tick(); frame = 1'b0;
      cnt = 0; guard = 0;
      while (int_n === 1'b0 && cnt < 20 && guard < 300) begin
         if (cep) cnt++;
         tick(); guard++;
      end
      frame = 1'b1; tick(); frame = 1'b0;
      while (int_n === 1'b0 && guard < 300) begin
         if (cep) cnt++;
         tick(); guard++;
      end
      check("int_len_retrigger_52", cnt, 52);

      // Frame coincident with the final decrement
      frame = 1'b1; tick(); frame = 1'b0;
      cnt = 0; guard = 0;
      while (int_n === 1'b0 && cnt < 31 && guard < 300) begin
         if (cep) cnt++;
         tick(); guard++;
      end
      if (!cep) tick();
      frame = 1'b1; tick(); frame = 1'b0;
      check("int_reload_wins", int_n, 0);
      while (int_n === 1'b0 && guard < 300) begin
         if (cep) cnt++;
         tick(); guard++;
      end
      check("int_len_expiry_63", cnt, 63);

      // Simultaneous mreq/iorq start: memory wins, I/O write to 0x7F ignored
      a = 16'h907F; wr = 1'b0; cpu_do = 8'h5A; mreq = 1'b0; iorq = 1'b0;
      guard = 0;
      while (mem_req !== 1'b1 && guard < 10) begin tick(); guard++; end
      check("both_start_mem_req", mem_req, 1);
      check("both_start_addr", mem_addr, exp_addr(16'h907F));
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      mreq = 1'b1; iorq = 1'b1; wr = 1'b1;
      repeat (4) tick();
      check("both_start_bank_kept", bank, bank_m);

      // Reset while waiting for ack
      io_cycle(8'h7F, 1'b1, 8'h03);
      a = 16'hC000; wr = 1'b1; mreq = 1'b0;
      guard = 0;
      while (mem_req !== 1'b1 && guard < 10) begin tick(); guard++; end
      check("pre_reset_req", mem_req, 1);
      reset = 1'b1; mreq = 1'b1;
      tick();
      reset = 1'b0;
      bank_m = 8'h00; vctrl_m = 8'h00; di_m = 8'hFF;
      check("reset_mid_mem_req", mem_req, 0);
      check("reset_mid_wait_n", wait_n, 1);
      check("reset_mid_bank", bank, 8'h00);
      check("reset_mid_di", di, 8'hFF);
      mem_ack = 1'b1; mem_rdata = 8'h77; tick(); mem_ack = 1'b0;
      tick();
      check("late_ack_req", mem_req, 0);
      check("late_ack_di", di, 8'hFF);

      // Randomized transactions against the model
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0, 1: begin
               case ($urandom_range(0, 3))
                  0: ad = 16'h5FFF;
                  1: ad = 16'h6000;
                  2: ad = 16'($urandom_range(0, 24575));
                  default: ad = 16'($urandom);
               endcase
               mem_cycle(ad, bit'($urandom_range(0, 1)), 8'($urandom),
                         $urandom_range(0, 6), 8'($urandom), $urandom_range(0, 4));
            end
            2: begin
               case ($urandom_range(0, 2))
                  0: pt = 8'h7F;
                  1: pt = 8'h80;
                  default: pt = 8'($urandom);
               endcase
               io_cycle(pt, 1'b1, 8'($urandom));
            end
            default: begin
               case ($urandom_range(0, 2))
                  0: pt = 8'h7F;
                  1: pt = 8'h80;
                  default: pt = 8'($urandom);
               endcase
               io_cycle(pt, 1'b0, 8'h00);
            end
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
